// File: rtl/demux_scan_pkg.sv
// demux_scan_pkg: shared constants, defaults and the select-width helper for demux_scan
package demux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHANNELS = 8;
    localparam int DEF_DWELL = 16;

    // Ceiling log2, never below 1 so single-value ranges still get a real bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/demux_scan_seq.sv
// demux_scan_seq: dwell counter and active-channel sequencing for manual and scan modes
module demux_scan_seq
    import demux_scan_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL = DEF_DWELL,
    parameter int SELW = clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SELW-1:0] sel_in,
    output logic [SELW-1:0] sel_cur,
    output logic            wrap,
    output logic            err
);
    localparam int CNTW = clog2(DWELL);
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);
    localparam logic [CNTW-1:0] CNT_END = CNTW'(DWELL - 1);

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic [SELW-1:0] sel_nxt;
    logic            wrap_nxt;
    logic            err_nxt;
    logic            in_range;
    logic            dwell_done;
    logic            scan;

    always_comb begin
        scan = (mode == MODE_SCAN);
        in_range = (32'(sel_in) < CHANNELS);
        dwell_done = (cnt == CNT_END);
        cnt_nxt = (scan && !dwell_done) ? cnt + 1'b1 : '0;
        sel_nxt = !scan ? (in_range ? sel_in : sel_cur) :
                  !dwell_done ? sel_cur :
                  (sel_cur == LAST) ? '0 : sel_cur + 1'b1;
        wrap_nxt = scan && dwell_done && (sel_cur == LAST);
        err_nxt = !scan && !in_range;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            sel_cur <= '0;
            wrap <= 1'b0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sel_cur <= sel_nxt;
            wrap <= wrap_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: rtl/demux_scan.sv
// demux_scan: registered 1-to-N demultiplexer with manual select or timed channel scan
module demux_scan
    import demux_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL = DEF_DWELL,
    localparam int SELW = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_valid,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel_in,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    output logic [CHANNELS-1:0]       o_valid,
    output logic [SELW-1:0]           sel_cur,
    output logic                      wrap,
    output logic                      err
);
    demux_scan_seq #(
        .CHANNELS(CHANNELS),
        .DWELL(DWELL),
        .SELW(SELW)
    ) u_seq (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .sel_in(sel_in),
        .sel_cur(sel_cur),
        .wrap(wrap),
        .err(err)
    );

    // Routing uses the registered select and error flag, so a select change lands one edge later
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic             hit;
        logic [WIDTH-1:0] q;
        logic             v;
        assign hit = !err && (sel_cur == SELW'(k));
        always_ff @(posedge clk) begin
            if (!reset) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                q <= hit ? i_data : '0;
                v <= hit && i_valid;
            end
        end
        assign o_data[k*WIDTH +: WIDTH] = q;
        assign o_valid[k] = v;
    end

endmodule

// File: tb/tb_demux_scan.sv
// tb_demux_scan: randomized and directed checks of three demux_scan configurations against a behavioural model
module tb_demux_scan;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_data = '0;
    logic       i_valid = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel_in = '0;

    logic [63:0] d8;
    logic [7:0]  v8;
    logic [2:0]  s8;
    logic        w8, e8;
    logic [47:0] d6;
    logic [5:0]  v6;
    logic [2:0]  s6;
    logic        w6, e6;
    logic [39:0] d5;
    logic [4:0]  v5;
    logic [2:0]  s5;
    logic        w5, e5;

    int tests = 0;
    int fails = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    demux_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) u8 (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o_data(d8), .o_valid(v8), .sel_cur(s8), .wrap(w8), .err(e8));
    demux_scan #(.WIDTH(8), .CHANNELS(6), .DWELL(4)) u6 (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o_data(d6), .o_valid(v6), .sel_cur(s6), .wrap(w6), .err(e6));
    demux_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) u5 (
        .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .mode(mode), .sel_in(sel_in),
        .o_data(d5), .o_valid(v5), .sel_cur(s5), .wrap(w5), .err(e5));

    logic [63:0] act_d[3];
    logic [7:0]  act_v[3];
    int          act_s[3];
    bit          act_w[3], act_e[3];
    assign act_d[0] = d8;
    assign act_d[1] = {16'b0, d6};
    assign act_d[2] = {24'b0, d5};
    assign act_v[0] = v8;
    assign act_v[1] = {2'b0, v6};
    assign act_v[2] = {3'b0, v5};
    assign act_s[0] = int'(s8);
    assign act_s[1] = int'(s6);
    assign act_s[2] = int'(s5);
    assign act_w[0] = w8;
    assign act_w[1] = w6;
    assign act_w[2] = w5;
    assign act_e[0] = e8;
    assign act_e[1] = e6;
    assign act_e[2] = e5;

    // Behavioural model: channel count and dwell per instance, stepped once per rising edge
    int          chn[3] = '{8, 6, 5};
    int          dw[3] = '{4, 4, 1};
    int          m_sel[3], m_cnt[3];
    bit          m_err[3], m_wrap[3];
    logic [63:0] e_d[3];
    logic [7:0]  e_v[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            e_d[i] = '0;
            e_v[i] = '0;
            if (!reset) begin
                m_sel[i] = 0;
                m_cnt[i] = 0;
                m_err[i] = 1'b0;
                m_wrap[i] = 1'b0;
            end else begin
                if (!m_err[i]) begin
                    e_d[i][m_sel[i]*8 +: 8] = i_data;
                    e_v[i][m_sel[i]] = i_valid;
                end
                m_wrap[i] = 1'b0;
                if (!mode) begin
                    m_cnt[i] = 0;
                    m_err[i] = (int'(sel_in) >= chn[i]);
                    if (!m_err[i]) m_sel[i] = int'(sel_in);
                end else begin
                    m_err[i] = 1'b0;
                    m_cnt[i]++;
                    if (m_cnt[i] == dw[i]) begin
                        m_cnt[i] = 0;
                        m_sel[i] = (m_sel[i] + 1) % chn[i];
                        m_wrap[i] = (m_sel[i] == 0);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_data[%0d]", i), longint'(act_d[i]), longint'(e_d[i]));
                chk($sformatf("model_valid[%0d]", i), longint'(act_v[i]), longint'(e_v[i]));
                chk($sformatf("model_sel[%0d]", i), longint'(act_s[i]), longint'(m_sel[i]));
                chk($sformatf("model_wrap[%0d]", i), longint'(act_w[i]), longint'(m_wrap[i]));
                chk($sformatf("model_err[%0d]", i), longint'(act_e[i]), longint'(m_err[i]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        en = 1'b1;
        chk("reset_valid", longint'(v8), 0);
        chk("reset_data", longint'(d8), 0);
        chk("reset_sel", longint'(s8), 0);

        reset = 1'b1;
        sel_in = 3'd5;
        i_data = 8'hA5;
        i_valid = 1'b1;
        tick(2);
        chk("manual_valid", longint'(v8), 64'h20);
        chk("manual_data", longint'(d8), 64'h0000_A500_0000_0000);

        sel_in = 3'd6;
        tick(1);
        mode = 1'b1;
        tick(3);
        chk("switch_hold6", longint'(s8), 6);
        tick(1);
        chk("switch_to7", longint'(s8), 7);
        tick(3);
        chk("switch_hold7", longint'(s8), 7);
        tick(1);
        chk("wrap_sel0", longint'(s8), 0);
        chk("wrap_high", longint'(w8), 1);
        tick(1);
        chk("wrap_low", longint'(w8), 0);
        chk("scan_valid_ch0", longint'(v8), 64'h01);

        for (int c = 0; c < 120; c++) begin
            i_data = 8'($urandom);
            i_valid = 1'(($urandom_range(0, 3) != 0));
            tick(1);
        end

        for (int c = 0; c < 102; c++) begin
            i_data = 8'($urandom);
            i_valid = 1'(((c / 17) % 2) == 0);
            tick(1);
        end

        mode = 1'b0;
        i_valid = 1'b1;
        i_data = 8'h3C;
        sel_in = 3'd2;
        tick(1);
        sel_in = 3'd7;
        tick(1);
        chk("oor_err", longint'(e6), 1);
        chk("oor_hold", longint'(s6), 2);
        tick(1);
        chk("oor_valid", longint'(v6), 0);
        chk("oor_data", longint'(d6), 0);
        sel_in = 3'd2;
        tick(1);
        chk("oor_clear", longint'(e6), 0);
        tick(1);
        chk("oor_resume_valid", longint'(v6), 64'h04);
        chk("oor_resume_data", longint'(d6), 64'h3C_0000);

        sel_in = 3'd3;
        tick(1);
        mode = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_mid_valid", longint'(v8), 0);
        chk("rst_mid_data", longint'(d8), 0);
        chk("rst_mid_sel", longint'(s8), 0);
        reset = 1'b1;
        tick(3);
        chk("rst_first_hold", longint'(s8), 0);
        tick(1);
        chk("rst_first_adv", longint'(s8), 1);

        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            reset = 1'(($urandom_range(0, 60) != 0));
            sel_in = 3'($urandom_range(0, 7));
            i_data = 8'($urandom);
            i_valid = 1'($urandom_range(0, 1));
            tick(1);
        end

        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux_scan.md
DEMUX_SCAN -- requirements
Module: demux_scan

Interface
REQ-001 Parameter WIDTH, default 8, is the data width per channel; legal range is 1 to 64.
REQ-002 Parameter CHANNELS, default 8, is the output channel count; legal range is 2 to 32.
REQ-003 Parameter DWELL, default 16, is the number of clocks spent on each channel in scan mode; legal range is 1 to 65535.
REQ-004 Derived constant SELW SHALL be clog2(CHANNELS), with a minimum of 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 Port i_data, input, WIDTH bits: the data to be routed.
REQ-008 Port i_valid, input, 1 bit: qualifies i_data.
REQ-009 Port mode, input, 1 bit: 0 selects manual mode, 1 selects scan mode.
REQ-010 Port sel_in, input, SELW bits: the manual channel select.
REQ-011 Port o_data, output, CHANNELS*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Port o_valid, output, CHANNELS bits: per-channel valid flags, at most one-hot.
REQ-013 Port sel_cur, output, SELW bits: the registered active channel.
REQ-014 Port wrap, output, 1 bit: a one-cycle pulse when the scan wraps from channel CHANNELS-1 to channel 0.
REQ-015 Port err, output, 1 bit: a registered flag indicating an out-of-range manual select.

Function
REQ-016 All outputs SHALL be registered, with 1-cycle latency from i_data/i_valid to o_data/o_valid.
REQ-017 On each clock, routing SHALL use the sel_cur value held before that edge; a select update and routing in the same cycle SHALL NOT interact combinationally.
REQ-018 In the selected slice, o_data SHALL be loaded with i_data and o_valid SHALL be loaded with i_valid; all other slices SHALL be driven to 0 with o_valid cleared.
REQ-019 When i_valid=0, the selected slice SHALL still load i_data, but its o_valid bit SHALL be 0.
REQ-020 Manual mode: sel_cur SHALL load sel_in each cycle, and the dwell counter SHALL be held at 0.
REQ-021 Manual mode, sel_in >= CHANNELS: sel_cur SHALL hold its value and err SHALL be set to 1.
REQ-022 Manual mode, sel_in >= CHANNELS, following cycle: routing SHALL be suppressed, with o_valid all 0 and o_data all 0.
REQ-023 Manual mode: err SHALL clear on the first in-range sel_in.
REQ-024 Scan mode: the dwell counter SHALL count 0..DWELL-1; on reaching DWELL-1 it SHALL return to 0 and sel_cur SHALL advance by 1.
REQ-025 Scan mode: sel_cur at CHANNELS-1 SHALL advance to 0, and wrap SHALL pulse high for that one cycle only.
REQ-026 Scan mode: err SHALL be forced to 0.
REQ-027 Switching from manual to scan SHALL start the scan from the current sel_cur with the dwell counter at 0.
REQ-028 Switching from scan to manual SHALL take effect on the next edge, and the dwell count SHALL be discarded.
REQ-029 With DWELL=1, sel_cur SHALL advance every clock.
REQ-030 For non-power-of-two CHANNELS, scan SHALL never visit an index >= CHANNELS.

Reset
REQ-031 reset=0 at a rising edge SHALL clear o_data, o_valid, sel_cur, wrap, err and the dwell counter to 0, overriding all other inputs.
REQ-032 Reset asserted mid-dwell or mid-transfer SHALL take effect on that edge, and the in-flight data SHALL be dropped.
REQ-033 After reset is released, the first scan advance SHALL occur DWELL clocks later.

Structure
REQ-034 Shared package demux_scan_pkg SHALL hold the clog2 function, the constants MODE_MANUAL=0 and MODE_SCAN=1, and the default parameter values.
REQ-035 The dwell/select sequencing SHALL live in one sub-module, demux_scan_seq, which takes clk, reset, mode, sel_in and outputs sel_cur, wrap and err.
REQ-036 The routing registers SHALL live in the top level and be generated per channel.

Verification (WIDTH=8, CHANNELS=8, DWELL=4 unless stated)
REQ-037 Manual routing: reset, then mode=0, sel_in=5, i_data=0xA5, i_valid=1 -> on the second edge after sel_in is applied, o_valid=0x20, slice 5=0xA5, and all other slices=0.
REQ-038 Scan sequencing: mode=1, i_valid=1 held -> sel_cur steps 0,1,...,7,0 every 4 clocks; wrap is high for exactly 1 clock when sel_cur goes 7->0; o_valid follows one-hot one cycle behind.
REQ-039 Out-of-range select: CHANNELS=6, manual mode, sel_in=7 -> err=1, sel_cur holds its previous value, o_valid=0; then sel_in=2 -> err=0 and routing resumes to channel 2.
REQ-040 Reset mid-dwell: reset=0 at dwell count 2 on sel_cur=3 -> next cycle all outputs are 0 and sel_cur=0; after release, the first advance to 1 occurs 4 clocks later.
REQ-041 Mode switch: manual at sel_in=6, then mode=1 -> sel_cur=6 for 4 clocks, then 7, then 0 with a wrap pulse.
REQ-042 Valid gating: toggle i_valid every 17 clocks during scan -> o_valid is asserted only in cycles following i_valid=1, and the data slice tracks i_data throughout.
